tcp_rx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one Tcp receive input (dataValid/data/newpkt byte stream) between four byte-stream sources such as PcapParser instances. It holds every non-granted source paused, grants one source for a whole packet, and forwards that packet's bytes to the Tcp parser with one cycle of latency. It enforces a minimum inter-packet gap and releases a stalled source after a timeout.

---
 rtl/tcp_rx_arbiter_if.sv | 34 +++
 rtl/tcp_rx_arbiter.sv | 132 +++++++++++++
 tb/tb_tcp_rx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_rx_arbiter_if.sv
// Byte-stream bundle between four sources, the arbiter and the Tcp parser.
// slave: arbiter side; master: the sources / parser side that drives it.
interface tcp_rx_arbiter_if;
  logic [3:0]  src_available;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_last;
  logic [3:0]  src_pause;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_newpkt;

  modport slave (
    input  src_available,
    input  src_valid,
    input  src_data,
    input  src_last,
    output src_pause,
    output out_valid,
    output out_data,
    output out_newpkt
  );

  modport master (
    output src_available,
    output src_valid,
    output src_data,
    output src_last,
    input  src_pause,
    input  out_valid,
    input  out_data,
    input  out_newpkt
  );
endinterface

// File: rtl/tcp_rx_arbiter.sv
// Packet-granular round-robin arbiter muxing four byte sources into one Tcp rx.
// Ports: CLOCK, RESETn, bus (slave), grant, busy, drop_count, timeout_count.
module tcp_rx_arbiter #(
  parameter int IFG     = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               CLOCK,
  input  logic               RESETn,
  tcp_rx_arbiter_if.slave    bus,
  output logic [1:0]         grant,
  output logic               busy,
  output logic [15:0]        drop_count,
  output logic [7:0]         timeout_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_XFER,
    S_GAP
  } state_t;

  localparam logic [15:0] TO_M  = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_M = 16'((IFG > 0) ? IFG - 1 : 0);
  localparam bit          NOGAP = (IFG == 0);

  state_t      state;
  logic [15:0] idle_cnt;
  logic [15:0] gap_cnt;

  logic [1:0]  pick;
  logic        pick_ok;
  logic [1:0]  idx;
  logic [3:0]  drop_mask;
  logic [2:0]  drop_n;
  logic [16:0] drop_sum;
  logic [15:0] drop_sat;
  logic [7:0]  gbyte;

  assign gbyte = bus.src_data[{grant, 3'b000} +: 8];

  // Search starts one past the last grant and wraps back to it last.
  always_comb begin
    pick    = grant;
    pick_ok = 1'b0;
    idx     = grant;
    for (int k = 1; k <= 4; k++) begin
      idx = grant + 2'(k);
      if (!pick_ok && bus.src_available[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  // Only the granted source's byte in XFER is kept; all others are drops.
  always_comb begin
    drop_mask = bus.src_valid;
    if (state == S_XFER)
      drop_mask[grant] = 1'b0;
    drop_n = {2'b00, drop_mask[0]} + {2'b00, drop_mask[1]}
           + {2'b00, drop_mask[2]} + {2'b00, drop_mask[3]};
    drop_sum = {1'b0, drop_count} + {14'd0, drop_n};
    drop_sat = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state          <= S_IDLE;
      idle_cnt       <= '0;
      gap_cnt        <= '0;
      grant          <= 2'd3;
      busy           <= 1'b0;
      drop_count     <= '0;
      timeout_count  <= '0;
      bus.src_pause  <= 4'hF;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= 8'h00;
      bus.out_newpkt <= 1'b0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.out_newpkt <= 1'b0;
      drop_count     <= drop_sat;
      unique case (state)
        S_IDLE: begin
          if (pick_ok) begin
            grant <= pick;
            busy  <= 1'b1;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          bus.src_pause[grant] <= 1'b0;
          bus.out_newpkt       <= 1'b1;
          idle_cnt             <= '0;
          state                <= S_XFER;
        end
        S_XFER: begin
          if (bus.src_valid[grant]) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= gbyte;
            idle_cnt      <= '0;
            if (bus.src_last[grant]) begin
              bus.src_pause <= 4'hF;
              gap_cnt       <= '0;
              busy          <= !NOGAP;
              state         <= NOGAP ? S_IDLE : S_GAP;
            end
          end else if (idle_cnt == TO_M) begin
            if (timeout_count != 8'hFF)
              timeout_count <= timeout_count + 8'd1;
            bus.src_pause <= 4'hF;
            gap_cnt       <= '0;
            busy          <= !NOGAP;
            state         <= NOGAP ? S_IDLE : S_GAP;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_M) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_rx_arbiter.sv
// Directed bench for tcp_rx_arbiter: vector table plus multi-cycle sequences.
// Runs with IFG=4, TIMEOUT=8.
module tb_tcp_rx_arbiter;
  logic        CLOCK = 1'b0;
  logic        RESETn;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] drop_count;
  logic [7:0]  timeout_count;

  int errors = 0;
  int checks = 0;

  tcp_rx_arbiter_if bus();

  tcp_rx_arbiter #(.IFG(4), .TIMEOUT(8)) dut (
    .CLOCK(CLOCK),
    .RESETn(RESETn),
    .bus(bus),
    .grant(grant),
    .busy(busy),
    .drop_count(drop_count),
    .timeout_count(timeout_count)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [3:0]  av;
    logic [3:0]  vl;
    logic [3:0]  ls;
    logic [31:0] dt;
    logic [3:0]  pz;
    logic        ov;
    logic [7:0]  od;
    logic        np;
    logic        bz;
    logic [1:0]  gr;
  } vec_t;

  vec_t tbl[$];

  int          sent[4];
  int          gseq[$];
  logic [7:0]  got[$];
  int          gaps[$];
  int          eg[5] = '{0, 1, 2, 3, 0};
  int          last_ov;
  int          nov;
  int          tcyc;
  int          ngr;
  int          ng;
  logic [3:0]  tpz;
  logic [16:0] act;
  logic [16:0] exp_v;
  bit          ok;

  task automatic add(input logic [3:0] av, input logic [3:0] vl,
                     input logic [3:0] ls, input logic [7:0] d,
                     input logic [3:0] pz, input logic ov,
                     input logic [7:0] od, input logic np,
                     input logic bz, input logic [1:0] gr);
    vec_t v;
    v.av = av; v.vl = vl; v.ls = ls; v.dt = {24'h0, d};
    v.pz = pz; v.ov = ov; v.od = od; v.np = np; v.bz = bz; v.gr = gr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  task automatic step;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_in;
    bus.src_available = '0;
    bus.src_valid     = '0;
    bus.src_data      = '0;
    bus.src_last      = '0;
  endtask

  task automatic do_reset;
    RESETn = 1'b0;
    idle_in();
    step();
    step();
    RESETn = 1'b1;
  endtask

  task automatic wait_unpaused(input int i, output bit found);
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (!bus.src_pause[i]) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    // Reset values, checked while reset is held.
    RESETn = 1'b0;
    idle_in();
    step();
    chk("rst_pause", 32'(bus.src_pause), 32'hF);
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_od", 32'(bus.out_data), 0);
    chk("rst_np", 32'(bus.out_newpkt), 0);
    chk("rst_grant", 32'(grant), 3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_tmo", 32'(timeout_count), 0);
    RESETn = 1'b1;

    // Single 6-byte packet from source 0; expected = outputs after the edge.
    //   av    vl    ls    data   pause  ov od     np bz gr
    add(4'h1, 4'h0, 4'h0, 8'h00, 4'hF, 0, 8'h00, 0, 1, 0);
    add(4'h1, 4'h0, 4'h0, 8'h00, 4'hE, 0, 8'h00, 1, 1, 0);
    add(4'h0, 4'h1, 4'h0, 8'h45, 4'hE, 1, 8'h45, 0, 1, 0);
    add(4'h0, 4'h1, 4'h0, 8'h46, 4'hE, 1, 8'h46, 0, 1, 0);
    add(4'h0, 4'h1, 4'h0, 8'h47, 4'hE, 1, 8'h47, 0, 1, 0);
    add(4'h0, 4'h1, 4'h0, 8'h48, 4'hE, 1, 8'h48, 0, 1, 0);
    add(4'h0, 4'h1, 4'h0, 8'h49, 4'hE, 1, 8'h49, 0, 1, 0);
    add(4'h0, 4'h1, 4'h1, 8'h4A, 4'hF, 1, 8'h4A, 0, 1, 0);
    add(4'h0, 4'h0, 4'h0, 8'h00, 4'hF, 0, 8'h00, 0, 1, 0);
    add(4'h0, 4'h0, 4'h0, 8'h00, 4'hF, 0, 8'h00, 0, 1, 0);
    add(4'h0, 4'h0, 4'h0, 8'h00, 4'hF, 0, 8'h00, 0, 1, 0);
    add(4'h0, 4'h0, 4'h0, 8'h00, 4'hF, 0, 8'h00, 0, 0, 0);
    add(4'h0, 4'h0, 4'h0, 8'h00, 4'hF, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      bus.src_available = tbl[i].av;
      bus.src_valid     = tbl[i].vl;
      bus.src_last      = tbl[i].ls;
      bus.src_data      = tbl[i].dt;
      step();
      act = {bus.src_pause, bus.out_valid,
             bus.out_valid ? bus.out_data : 8'h00,
             bus.out_newpkt, busy, grant};
      exp_v = {tbl[i].pz, tbl[i].ov, tbl[i].od,
               tbl[i].np, tbl[i].bz, tbl[i].gr};
      chk($sformatf("vec%0d", i), 32'(act), 32'(exp_v));
    end
    idle_in();

    // Four sources always available, 3-byte packets each.
    do_reset();
    for (int i = 0; i < 4; i++) sent[i] = 0;
    last_ov = -100;
    bus.src_available = 4'hF;
    for (int c = 0; c < 200 && got.size() < 15; c++) begin
      bus.src_valid = '0;
      bus.src_last  = '0;
      for (int i = 0; i < 4; i++) begin
        if (bus.src_pause[i]) begin
          sent[i] = 0;
        end else if (sent[i] < 3) begin
          bus.src_valid[i]        = 1'b1;
          bus.src_data[8*i +: 8]  = 8'((i + 1) * 16 + sent[i]);
          bus.src_last[i]         = (sent[i] == 2);
          sent[i]++;
        end
      end
      step();
      if (bus.out_newpkt) begin
        gseq.push_back(int'(grant));
        if (gseq.size() > 1) gaps.push_back(c - last_ov);
      end
      if (bus.out_valid) begin
        got.push_back(bus.out_data);
        last_ov = c;
      end
    end
    idle_in();
    chk("rr_npkts", 32'(gseq.size()), 5);
    for (int k = 0; k < gseq.size() && k < 5; k++)
      chk($sformatf("rr_grant%0d", k), 32'(gseq[k]), 32'(eg[k]));
    chk("rr_nbytes", 32'(got.size()), 15);
    for (int k = 0; k < got.size() && k < 15; k++)
      chk($sformatf("rr_byte%0d", k), 32'(got[k]),
          32'((eg[k / 3] + 1) * 16 + k % 3));
    chk("rr_ngaps", 32'(gaps.size()), 4);
    foreach (gaps[k])
      chk($sformatf("rr_gap%0d", k), 32'(gaps[k]), 6);
    chk("rr_drop", 32'(drop_count), 0);

    // Source 1 granted while source 2 streams for 5 cycles.
    do_reset();
    bus.src_available = 4'b0010;
    wait_unpaused(1, ok);
    chk("drp_unpause", 32'(ok), 1);
    chk("drp_grant", 32'(grant), 1);
    bus.src_available = '0;
    got.delete();
    for (int k = 0; k < 5; k++) begin
      bus.src_valid = 4'b0110;
      bus.src_data  = {8'h00, 8'hEE, 8'(8'hA0 + k), 8'h00};
      bus.src_last  = (k == 4) ? 4'b0110 : 4'b0100;
      step();
      if (bus.out_valid) got.push_back(bus.out_data);
    end
    idle_in();
    step();
    if (bus.out_valid) got.push_back(bus.out_data);
    chk("drp_nbytes", 32'(got.size()), 5);
    for (int k = 0; k < got.size() && k < 5; k++)
      chk($sformatf("drp_byte%0d", k), 32'(got[k]), 32'(8'hA0 + k));
    chk("drp_count", 32'(drop_count), 5);

    // Source 0 sends 2 bytes then stalls; source 1 waits its turn.
    do_reset();
    bus.src_available = 4'b0011;
    wait_unpaused(0, ok);
    chk("tmo_unpause", 32'(ok), 1);
    nov = 0;
    for (int k = 0; k < 2; k++) begin
      bus.src_valid = 4'b0001;
      bus.src_data  = {24'h0, 8'(8'h30 + k)};
      step();
      if (bus.out_valid) nov++;
    end
    bus.src_valid = '0;
    tcyc = -1;
    ngr  = -1;
    ng   = -1;
    tpz  = '0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (bus.out_valid) nov++;
      if (tcyc < 0 && timeout_count == 8'd1) begin
        tcyc = c;
        tpz  = bus.src_pause;
      end
      if (ngr < 0 && bus.out_newpkt) begin
        ngr = c;
        ng  = int'(grant);
      end
    end
    idle_in();
    chk("tmo_nbytes", 32'(nov), 2);
    chk("tmo_cycle", 32'(tcyc), 8);
    chk("tmo_pause", 32'(tpz), 32'hF);
    chk("tmo_next_np", 32'(ngr), 14);
    chk("tmo_next_grant", 32'(ng), 1);

    // Three sources dropping every cycle until saturation.
    do_reset();
    bus.src_valid = 4'b0111;
    repeat (10) step();
    chk("sat_partial", 32'(drop_count), 30);
    repeat (21836) step();
    chk("sat_full", 32'(drop_count), 32'hFFFF);
    step();
    chk("sat_hold", 32'(drop_count), 32'hFFFF);
    idle_in();

    // Reset pulsed in the middle of a packet from source 2.
    do_reset();
    bus.src_available = 4'b0100;
    wait_unpaused(2, ok);
    chk("mrst_unpause", 32'(ok), 1);
    bus.src_available = '0;
    bus.src_valid     = 4'b0100;
    bus.src_data      = 32'h0077_0000;
    step();
    chk("mrst_ov_before", 32'(bus.out_valid), 1);
    step();
    #2;
    RESETn = 1'b0;
    #1;
    chk("mrst_ov", 32'(bus.out_valid), 0);
    chk("mrst_pause", 32'(bus.src_pause), 32'hF);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_grant", 32'(grant), 3);
    idle_in();
    step();
    RESETn = 1'b1;
    bus.src_available = 4'b0110;
    ngr = -1;
    ng  = -1;
    for (int c = 0; c < 10 && ngr < 0; c++) begin
      step();
      if (bus.out_newpkt) begin
        ngr = c;
        ng  = int'(grant);
      end
    end
    idle_in();
    chk("mrst_np_seen", 32'(ngr >= 0), 1);
    chk("mrst_first_grant", 32'(ng), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
